// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard control. Produces the stall, flush and forwarding
// controls for the pipeline registers and operand muxes. It also runs a
// syscall drain/handshake FSM and counts the cycles in which decode is stalled.
//
// Handshake: o_syscall_req is a registered level. It rises one edge after the
// FSM enters REQ and stays high until the edge on which i_syscall_ack is
// sampled high in WAIT. i_syscall_ack has no effect in any other state.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_rs_d, i_rt_d, i_branch_d   decode-stage sources and branch flag
//   i_rs_e, i_rt_e, i_write_reg_e, i_reg_write_e, i_mem_to_reg_e, i_syscall_e
//                                execute-stage fields
//   i_write_reg_m, i_reg_write_m, i_mem_to_reg_m   memory-stage fields
//   i_write_reg_w, i_reg_write_w                   writeback-stage fields
//   i_syscall_ack                handler finished
//   o_stall_f, o_stall_d         hold PC and F->D register
//   o_flush_e                    clear D->E register
//   o_forward_a_e/b_e            00 regfile, 01 W result, 10 M result
//   o_forward_a_d/b_d            D comparator takes M result
//   o_syscall_req, o_syscall_busy, o_stall_cnt
//   o_state                      debug view of FSM state (RUN=0, DRAIN=1, REQ=2, WAIT=3)
module hazard_unit #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs_d,
  input  logic [4:0]       i_rt_d,
  input  logic             i_branch_d,
  input  logic [4:0]       i_rs_e,
  input  logic [4:0]       i_rt_e,
  input  logic [4:0]       i_write_reg_e,
  input  logic             i_reg_write_e,
  input  logic             i_mem_to_reg_e,
  input  logic             i_syscall_e,
  input  logic [4:0]       i_write_reg_m,
  input  logic             i_reg_write_m,
  input  logic             i_mem_to_reg_m,
  input  logic [4:0]       i_write_reg_w,
  input  logic             i_reg_write_w,
  input  logic             i_syscall_ack,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_e,
  output logic [1:0]       o_forward_a_e,
  output logic [1:0]       o_forward_b_e,
  output logic             o_forward_a_d,
  output logic             o_forward_b_d,
  output logic             o_syscall_req,
  output logic             o_syscall_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [1:0]       o_state
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_REQ   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t         r_state, w_next;
  logic [DW-1:0]  r_drain, w_drain_next;
  logic           r_req, w_req_next;
  logic [CNT_W-1:0] r_cnt;
  logic           w_stall;

  // Forwarding: M wins over W, register 0 is never forwarded.
  logic w_fa_m, w_fa_w, w_fb_m, w_fb_w;
  assign w_fa_m = i_reg_write_m && (i_write_reg_m == i_rs_e) && (i_rs_e != 5'd0);
  assign w_fa_w = i_reg_write_w && (i_write_reg_w == i_rs_e) && (i_rs_e != 5'd0);
  assign w_fb_m = i_reg_write_m && (i_write_reg_m == i_rt_e) && (i_rt_e != 5'd0);
  assign w_fb_w = i_reg_write_w && (i_write_reg_w == i_rt_e) && (i_rt_e != 5'd0);

  assign o_forward_a_e = w_fa_m ? 2'b10 : (w_fa_w ? 2'b01 : 2'b00);
  assign o_forward_b_e = w_fb_m ? 2'b10 : (w_fb_w ? 2'b01 : 2'b00);
  assign o_forward_a_d = i_reg_write_m && (i_write_reg_m == i_rs_d) && (i_rs_d != 5'd0);
  assign o_forward_b_d = i_reg_write_m && (i_write_reg_m == i_rt_d) && (i_rt_d != 5'd0);

  // Hazard terms.
  logic w_lwstall, w_brstall, w_hz, w_br_e, w_br_m;
  assign w_lwstall = i_mem_to_reg_e && (i_rt_e != 5'd0) &&
                     ((i_rt_e == i_rs_d) || (i_rt_e == i_rt_d));
  assign w_br_e    = i_reg_write_e && (i_write_reg_e != 5'd0) &&
                     ((i_write_reg_e == i_rs_d) || (i_write_reg_e == i_rt_d));
  assign w_br_m    = i_mem_to_reg_m && (i_write_reg_m != 5'd0) &&
                     ((i_write_reg_m == i_rs_d) || (i_write_reg_m == i_rt_d));
  assign w_brstall = i_branch_d && (w_br_e || w_br_m);
  assign w_hz      = w_lwstall || w_brstall;

  always_comb begin
    w_next       = r_state;
    w_drain_next = r_drain;
    w_req_next   = r_req;
    w_stall      = 1'b1;
    case (r_state)
      S_RUN: begin
        w_stall = w_hz || i_syscall_e;
        if (i_syscall_e) begin
          // With one or zero drain cycles there is no DRAIN dwell at all.
          if (DRAIN_CYCLES > 1) begin
            w_next       = S_DRAIN;
            w_drain_next = DW'(DRAIN_CYCLES - 1);
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        // The counter reaching 0 on this edge means the drain is done.
        if (r_drain <= DW'(1)) begin
          w_next       = S_REQ;
          w_drain_next = '0;
        end else begin
          w_drain_next = r_drain - DW'(1);
        end
      end
      S_REQ: begin
        w_req_next = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (i_syscall_ack) begin
          w_req_next = 1'b0;
          w_next     = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  // Reset forces a flush so E is cleared, while F/D are not held.
  assign o_flush_e      = i_rst || w_stall;
  assign o_stall_f      = !i_rst && w_stall;
  assign o_stall_d      = !i_rst && w_stall;
  assign o_syscall_req  = r_req;
  assign o_syscall_busy = (r_state != S_RUN);
  assign o_stall_cnt    = r_cnt;
  assign o_state        = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_drain <= '0;
      r_req   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_next;
      r_req   <= w_req_next;
      if (o_stall_d && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic branch_d, reg_write_e, mem_to_reg_e, syscall_e;
  logic reg_write_m, mem_to_reg_m, reg_write_w, syscall_ack;
  logic stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, req, busy;
  logic [1:0] fwd_a_e, fwd_b_e, state;
  logic [31:0] cnt;
  logic s_stall_f, s_stall_d, s_flush_e, s_fad, s_fbd, s_req, s_busy;
  logic [1:0] s_fae, s_fbe, s_state;
  logic [3:0] cnt4;

  int checks = 0;
  int errors = 0;

  // Behavioural model: syscall timeline tracked as age since the syscall.
  bit          m_in_sys;
  int          m_age;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  always #5 clk = ~clk;

  hazard_unit #(.DRAIN_CYCLES(D), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_rs_d(rs_d), .i_rt_d(rt_d), .i_branch_d(branch_d),
    .i_rs_e(rs_e), .i_rt_e(rt_e), .i_write_reg_e(write_reg_e),
    .i_reg_write_e(reg_write_e), .i_mem_to_reg_e(mem_to_reg_e), .i_syscall_e(syscall_e),
    .i_write_reg_m(write_reg_m), .i_reg_write_m(reg_write_m), .i_mem_to_reg_m(mem_to_reg_m),
    .i_write_reg_w(write_reg_w), .i_reg_write_w(reg_write_w), .i_syscall_ack(syscall_ack),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_e(flush_e),
    .o_forward_a_e(fwd_a_e), .o_forward_b_e(fwd_b_e),
    .o_forward_a_d(fwd_a_d), .o_forward_b_d(fwd_b_d),
    .o_syscall_req(req), .o_syscall_busy(busy), .o_stall_cnt(cnt), .o_state(state)
  );

  hazard_unit #(.DRAIN_CYCLES(D), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_rs_d(rs_d), .i_rt_d(rt_d), .i_branch_d(branch_d),
    .i_rs_e(rs_e), .i_rt_e(rt_e), .i_write_reg_e(write_reg_e),
    .i_reg_write_e(reg_write_e), .i_mem_to_reg_e(mem_to_reg_e), .i_syscall_e(syscall_e),
    .i_write_reg_m(write_reg_m), .i_reg_write_m(reg_write_m), .i_mem_to_reg_m(mem_to_reg_m),
    .i_write_reg_w(write_reg_w), .i_reg_write_w(reg_write_w), .i_syscall_ack(syscall_ack),
    .o_stall_f(s_stall_f), .o_stall_d(s_stall_d), .o_flush_e(s_flush_e),
    .o_forward_a_e(s_fae), .o_forward_b_e(s_fbe),
    .o_forward_a_d(s_fad), .o_forward_b_d(s_fbd),
    .o_syscall_req(s_req), .o_syscall_busy(s_busy), .o_stall_cnt(cnt4), .o_state(s_state)
  );

  function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (reg_write_m && write_reg_m == src) return 2'b10;
    if (reg_write_w && write_reg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_fwd_d(input logic [4:0] src);
    return (src != 0) && reg_write_m && (write_reg_m == src);
  endfunction

  function automatic logic m_hz();
    logic uses_e, uses_m, lw;
    lw     = mem_to_reg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
    uses_e = reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d);
    uses_m = mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d);
    return lw || (branch_d && (uses_e || uses_m));
  endfunction

  function automatic logic m_stall();
    if (rst) return 1'b0;
    return m_in_sys || m_hz() || syscall_e;
  endfunction

  function automatic logic m_flush();
    return rst || m_in_sys || m_hz() || syscall_e;
  endfunction

  function automatic logic m_req();
    return m_in_sys && (m_age >= D + 1);
  endfunction

  // Advance one clock edge, updating the model from the inputs in effect.
  task automatic tick();
    logic st;
    st = m_stall();
    if (rst) begin
      m_in_sys = 0; m_age = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (st) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
      if (!m_in_sys) begin
        if (syscall_e) begin m_in_sys = 1; m_age = 1; end
      end else if (m_age >= D + 1 && syscall_ack) begin
        m_in_sys = 0; m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; branch_d = 0; rs_e = 0; rt_e = 0; write_reg_e = 0;
    reg_write_e = 0; mem_to_reg_e = 0; syscall_e = 0; write_reg_m = 0;
    reg_write_m = 0; mem_to_reg_m = 0; write_reg_w = 0; reg_write_w = 0;
    syscall_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick(); tick();
    checks++; if (flush_e !== 1'b1) begin errors++; $display("FAIL reset_flush got %b exp 1", flush_e); end
    checks++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall got %b%b exp 00", stall_f, stall_d); end
    checks++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_req_busy got %b%b exp 00", req, busy); end
    checks++; if (cnt !== 32'd0 || cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt, cnt4); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    // hazards during reset still must not stall
    mem_to_reg_e = 1; rt_e = 8; rs_d = 8; syscall_e = 1; #1;
    checks++; if (stall_d !== 1'b0 || flush_e !== 1'b1) begin errors++; $display("FAIL reset_hz stall %b flush %b exp 0 1", stall_d, flush_e); end
    tick();
    clear_inputs(); rst = 0; tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rs_e = 5; reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; #1;
    checks++; if (fwd_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_m got %b exp 10", fwd_a_e); end
    reg_write_m = 0; #1;
    checks++; if (fwd_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_w got %b exp 01", fwd_a_e); end
    rs_e = 0; #1;
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("FAIL fwd_a_r0 got %b exp 00", fwd_a_e); end
    rt_e = 7; reg_write_m = 1; write_reg_m = 7; write_reg_w = 7; #1;
    checks++; if (fwd_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_m got %b exp 10", fwd_b_e); end
    rt_d = 7; #1;
    checks++; if (fwd_b_d !== 1'b1 || fwd_a_d !== 1'b0) begin errors++; $display("FAIL fwd_d got a%b b%b exp a0 b1", fwd_a_d, fwd_b_d); end
    clear_inputs(); tick();
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    clear_inputs();
    c0 = m_cnt;
    mem_to_reg_e = 1; rt_e = 8; rs_d = 8; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("FAIL lw_stall got %b exp 111", {stall_f, stall_d, flush_e}); end
    tick();
    clear_inputs(); #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lw_release got %b exp 000", {stall_f, stall_d, flush_e}); end
    checks++; if (cnt !== c0 + 1) begin errors++; $display("FAIL lw_cnt got %0d exp %0d", cnt, c0 + 1); end
    mem_to_reg_e = 1; rt_e = 0; rs_d = 0; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lw_r0 got %b exp 0", stall_d); end
    clear_inputs(); tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_d = 1; rs_d = 3; mem_to_reg_m = 1; write_reg_m = 3; #1;
    checks++; if (stall_d !== 1'b1 || flush_e !== 1'b1) begin errors++; $display("FAIL br_m_stall got %b%b exp 11", stall_d, flush_e); end
    mem_to_reg_m = 0; reg_write_m = 1; #1;
    checks++; if (stall_d !== 1'b0 || fwd_a_d !== 1'b1) begin errors++; $display("FAIL br_fwd stall %b fwd %b exp 0 1", stall_d, fwd_a_d); end
    reg_write_m = 0; reg_write_e = 1; write_reg_e = 3; #1;
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL br_e_stall got %b exp 1", stall_f); end
    clear_inputs(); tick();
  endtask

  task automatic test_syscall();
    do_reset();
    syscall_e = 1; #1;                                    // cycle 10
    checks++; if (flush_e !== 1'b1 || stall_f !== 1'b1) begin errors++; $display("FAIL sc_c10 flush %b stall %b exp 1 1", flush_e, stall_f); end
    tick(); syscall_e = 0; #1;                            // cycle 11
    checks++; if (flush_e !== 1'b1 || req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sc_c11 f%b r%b b%b exp 1 0 1", flush_e, req, busy); end
    tick();                                               // cycle 12
    checks++; if (flush_e !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL sc_c12 f%b r%b exp 1 0", flush_e, req); end
    tick();                                               // cycle 13
    checks++; if (req !== 1'b1 || stall_d !== 1'b1) begin errors++; $display("FAIL sc_c13 r%b s%b exp 1 1", req, stall_d); end
    tick(); tick(); syscall_ack = 1; #1;                  // cycle 15
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL sc_c15 req got %b exp 1", req); end
    tick(); syscall_ack = 0; #1;                          // cycle 16
    checks++; if (req !== 1'b0 || busy !== 1'b0 || stall_d !== 1'b0) begin errors++; $display("FAIL sc_c16 r%b b%b s%b exp 0 0 0", req, busy, stall_d); end
    checks++; if (cnt !== 32'd6) begin errors++; $display("FAIL sc_cnt got %0d exp 6", cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    syscall_ack = 1;                       // ack held: ignored until WAIT
    syscall_e = 1; tick(); syscall_e = 0;
    checks++; if (busy !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL b2b_drain b%b r%b exp 1 0", busy, req); end
    tick();
    checks++; if (busy !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL b2b_req b%b r%b exp 1 0", busy, req); end
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL b2b_wait req %b exp 1", req); end
    tick(); syscall_ack = 0; #1;           // cycle N+4: back in RUN
    checks++; if (busy !== 1'b0 || stall_d !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL b2b_run b%b s%b r%b exp 0 0 0", busy, stall_d, req); end
    syscall_e = 1; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL b2b_second stall %b exp 1", stall_d); end
    tick(); syscall_e = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy %b exp 1", busy); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    syscall_e = 1; tick(); syscall_e = 0;
    for (int i = 0; i < D + 1; i++) tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rw_in_wait req %b exp 1", req); end
    rst = 1; syscall_ack = 1; #1;
    checks++; if (flush_e !== 1'b1 || stall_d !== 1'b0) begin errors++; $display("FAIL rw_during f%b s%b exp 1 0", flush_e, stall_d); end
    tick();
    checks++; if (state !== 2'd0 || req !== 1'b0 || busy !== 1'b0 || cnt !== 32'd0) begin errors++; $display("FAIL rw_after st%0d r%b b%b c%0d exp 0 0 0 0", state, req, busy, cnt); end
    checks++; if (flush_e !== 1'b1) begin errors++; $display("FAIL rw_held flush %b exp 1", flush_e); end
    rst = 0; syscall_ack = 0; tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d exp 15", cnt4); end
    checks++; if (cnt !== 32'd20) begin errors++; $display("FAIL sat_cnt32 got %0d exp 20", cnt); end
    clear_inputs(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      rs_d         = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e         = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      write_reg_e  = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w  = 5'($urandom_range(0, 3));
      branch_d     = 1'($urandom_range(0, 1)); reg_write_e = 1'($urandom_range(0, 1));
      mem_to_reg_e = ($urandom_range(0, 3) == 0); reg_write_m = 1'($urandom_range(0, 1));
      mem_to_reg_m = ($urandom_range(0, 3) == 0); reg_write_w = 1'($urandom_range(0, 1));
      syscall_e    = ($urandom_range(0, 19) == 0);
      syscall_ack  = ($urandom_range(0, 9) < 3);
      #1;
      checks++; if (stall_f !== m_stall() || stall_d !== m_stall()) begin errors++; $display("FAIL rnd_stall n%0d got %b%b exp %b", n, stall_f, stall_d, m_stall()); end
      checks++; if (flush_e !== m_flush()) begin errors++; $display("FAIL rnd_flush n%0d got %b exp %b", n, flush_e, m_flush()); end
      checks++; if (fwd_a_e !== m_fwd_e(rs_e) || fwd_b_e !== m_fwd_e(rt_e)) begin errors++; $display("FAIL rnd_fwd_e n%0d got %b/%b exp %b/%b", n, fwd_a_e, fwd_b_e, m_fwd_e(rs_e), m_fwd_e(rt_e)); end
      checks++; if (fwd_a_d !== m_fwd_d(rs_d) || fwd_b_d !== m_fwd_d(rt_d)) begin errors++; $display("FAIL rnd_fwd_d n%0d got %b/%b exp %b/%b", n, fwd_a_d, fwd_b_d, m_fwd_d(rs_d), m_fwd_d(rt_d)); end
      checks++; if (req !== m_req() || busy !== m_in_sys) begin errors++; $display("FAIL rnd_sys n%0d req %b busy %b exp %b %b", n, req, busy, m_req(), m_in_sys); end
      checks++; if (cnt !== m_cnt || cnt4 !== m_cnt4) begin errors++; $display("FAIL rnd_cnt n%0d got %0d/%0d exp %0d/%0d", n, cnt, cnt4, m_cnt, m_cnt4); end
      tick();
    end
    clear_inputs(); rst = 0; tick();
  endtask

  initial begin
    m_in_sys = 0; m_age = 0; m_cnt = 0; m_cnt4 = 0;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_syscall();
    test_back_to_back();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
